// File: rtl/mult_seq_ctrl_if.sv
// Bus between the multiply sequencer and the shared W-bit ripple-carry adder slice.
// The sequencer is the master; the adder answers combinationally in the same cycle.
interface mult_seq_ctrl_if #(
  parameter int W = 4
);
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_ci;
  logic [W-1:0] add_s;
  logic         add_co;

  modport master (
    output add_a,
    output add_b,
    output add_ci,
    input  add_s,
    input  add_co
  );

  modport slave (
    input  add_a,
    input  add_b,
    input  add_ci,
    output add_s,
    output add_co
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Unsigned W x W shift-and-add multiplier sequencer: one pass through the external
// adder per multiplier bit, accumulator {acc_hi, acc_lo} shifted right each pass.
module mult_seq_ctrl #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W-1:0]        mcand,
  input  logic [W-1:0]        mplier,
  mult_seq_ctrl_if.master     adder,
  output logic                busy,
  output logic                done,
  output logic [2*W-1:0]      product
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [W-1:0]   acc_hi_r;
  logic [W-1:0]   acc_lo_r;
  logic [W-1:0]   mcand_r;
  logic [CW-1:0]  cnt_r;
  logic           busy_r;
  logic           done_r;
  logic [2*W-1:0] product_r;
  logic           accept_s;
  logic [W-1:0]   add_a_s;
  logic [W-1:0]   add_b_s;
  logic [2*W-1:0] shift_s;

  // The adder carry becomes the new MSB, so the 2W-bit accumulator never overflows.
  assign shift_s = {adder.add_co, adder.add_s, acc_lo_r[W-1:1]};

  // Next-state decode, start acceptance and adder operand drive.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    add_a_s     = {W{1'b0}};
    add_b_s     = {W{1'b0}};
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        add_a_s = acc_hi_r;
        add_b_s = acc_lo_r[0] ? mcand_r : {W{1'b0}};
        if (cnt_r == CW'(W - 1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign adder.add_a  = add_a_s;
  assign adder.add_b  = add_b_s;
  assign adder.add_ci = 1'b0;

  // State, datapath and registered status/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      acc_hi_r  <= {W{1'b0}};
      acc_lo_r  <= {W{1'b0}};
      mcand_r   <= {W{1'b0}};
      cnt_r     <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*W){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_r == RUN) && (state_nxt_s == DONE);
      if (accept_s) begin
        mcand_r  <= mcand;
        acc_lo_r <= mplier;
        acc_hi_r <= {W{1'b0}};
        cnt_r    <= {CW{1'b0}};
      end else if (state_r == RUN) begin
        {acc_hi_r, acc_lo_r} <= shift_s;
        cnt_r                <= cnt_r + 1'b1;
        if (state_nxt_s == DONE) begin
          product_r <= shift_s;
        end
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: a cycle-indexed arithmetic model predicts
// accepted requests, products, done timing and adder operands; a monitor compares.
module tb_mult_seq_ctrl;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  mult_seq_ctrl_if #(.W(W)) add_bus ();

  mult_seq_ctrl #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .adder   (add_bus.master),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Behavioural stand-in for the external ripple-carry adder slice.
  assign {add_bus.add_co, add_bus.add_s} = add_bus.add_a + add_bus.add_b + {{(W-1){1'b0}}, add_bus.add_ci};

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;

  exp_t           q[$];
  int             cyc = 0;
  int             free_at = 0;
  int             run_start = -100;
  logic [W-1:0]   run_mc = '0;
  logic [W-1:0]   run_mp = '0;
  logic [2*W-1:0] last_prod = '0;
  int             tests = 0;
  int             fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a request is taken when the unit is free; product and done
  // time follow from plain arithmetic (done W edges after the accepting edge).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      free_at   <= 0;
      run_start <= -100;
    end else begin
      cyc <= cyc + 1;
      if (start && (cyc + 1 >= free_at)) begin
        q.push_back('{prod: (2*W)'(int'(mcand) * int'(mplier)), due: cyc + 1 + W});
        free_at   <= cyc + 1 + W + 1;
        run_start <= cyc + 1;
        run_mc    <= mcand;
        run_mp    <= mplier;
      end
    end
  end

  // Monitor: compare every output mid-cycle against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_prod <= '0;
    end else begin
      automatic int             i = cyc - run_start;
      automatic logic           in_run = (i >= 0) && (i < W);
      automatic logic [W-1:0]   exp_a = '0;
      automatic logic [W-1:0]   exp_b = '0;
      automatic logic           exp_done;
      automatic logic [2*W-1:0] exp_p;
      if (in_run) begin
        exp_b = run_mp[i] ? run_mc : '0;
        exp_a = W'((int'(run_mc) * (int'(run_mp) & ((1 << i) - 1))) >> i);
      end
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      exp_p    = exp_done ? q[0].prod : last_prod;
      chk("busy", busy, in_run);
      chk("add_a", add_bus.add_a, exp_a);
      chk("add_b", add_bus.add_b, exp_b);
      chk("add_ci", add_bus.add_ci, 1'b0);
      chk("done", done, exp_done);
      chk("product", product, exp_p);
      if ((q.size() > 0) && (q[0].due <= cyc)) begin
        last_prod <= q[0].prod;
        q.pop_front();
      end
    end
  end

  task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_product", product, '0);
    chk("rst_add_a", add_bus.add_a, '0);
    rst_n = 1'b1;

    pulse(4'd5, 4'd3);   idle(W + 2);
    pulse(4'd15, 4'd15); idle(W + 2);
    pulse(4'd0, 4'd9);   idle(W + 2);
    pulse(4'd9, 4'd0);   idle(W + 2);

    pulse(4'd7, 4'd6);
    pulse(4'd2, 4'd2);
    idle(W + 2);

    pulse(4'd3, 4'd3);
    idle(W - 1);
    pulse(4'd4, 4'd4);
    idle(W + 2);

    pulse(4'd13, 4'd11);
    idle(2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_product", product, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    pulse(4'd2, 4'd7);
    idle(W + 2);

    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      start  = ($urandom_range(0, 2) == 0);
      mcand  = ($urandom_range(0, 3) == 0) ? 4'hF : W'($urandom);
      mplier = ($urandom_range(0, 3) == 0) ? 4'h0 : W'($urandom);
    end
    start = 1'b0;
    idle(W + 4);
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
